// File: rtl/rank_dispatch_if.sv
// Host-side handshake for rank_dispatch.
// The host drives commands and write data. The dispatcher returns ready and in-order read data.
interface rank_dispatch_if #(
  parameter int RANK_BITS = 2,
  parameter int CMD_BITS  = 32,
  parameter int DATA_BITS = 64
);
  logic [RANK_BITS+CMD_BITS-1:0] command;
  logic                          valid;
  logic                          ready;
  logic [DATA_BITS-1:0]          write_data;
  logic [DATA_BITS-1:0]          read_data;
  logic                          read_data_valid;

  modport master (
    output command, valid, write_data,
    input  ready, read_data, read_data_valid
  );

  modport slave (
    input  command, valid, write_data,
    output ready, read_data, read_data_valid
  );
endinterface

// File: rtl/rank_dispatch.sv
// Rank command dispatcher.
// A one-entry hold register fans each command out to the rank it selects.
// A read-order queue records the rank of every accepted read. Read returns are
// forwarded in acceptance order, and a return from any rank other than the
// queue head is dropped and flagged.
module rank_dispatch #(
  parameter int NUM_RANKS = 4,
  parameter int RANK_BITS = $clog2(NUM_RANKS),
  parameter int CMD_BITS  = 32,
  parameter int DATA_BITS = 64,
  parameter int RDQ_DEPTH = 8,
  localparam int PTR_BITS = $clog2(RDQ_DEPTH)
) (
  input  logic                           clk,
  input  logic                           power_on_rst_n,
  rank_dispatch_if.slave                 host,
  output logic [NUM_RANKS*CMD_BITS-1:0]  rank_command,
  output logic [NUM_RANKS*DATA_BITS-1:0] rank_write_data,
  output logic [NUM_RANKS-1:0]           rank_valid,
  input  logic [NUM_RANKS-1:0]           rank_ready,
  input  logic [NUM_RANKS*DATA_BITS-1:0] rank_read_data,
  input  logic [NUM_RANKS-1:0]           rank_read_data_valid,
  input  logic [NUM_RANKS*4-1:0]         rank_ba_cmd_pm,
  output logic [3:0]                     ba_cmd_pm,
  output logic [PTR_BITS:0]              rdq_count,
  output logic                           order_err
);

  logic                 held;
  logic [RANK_BITS-1:0] hrank;
  logic [CMD_BITS-1:0]  hcmd;
  logic [DATA_BITS-1:0] hdata;
  logic [RANK_BITS-1:0] lrank;

  logic [RANK_BITS-1:0] rdq_mem [RDQ_DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr;
  logic [PTR_BITS-1:0]  rd_ptr;
  logic [RANK_BITS-1:0] head;

  logic [RANK_BITS-1:0] in_rank;
  logic                 in_read;
  logic                 transfer;
  logic                 ready;
  logic                 accept;
  logic                 push;
  logic                 rdq_pop;
  logic                 rdq_full;
  logic [NUM_RANKS-1:0] pop_mask;

  logic [DATA_BITS-1:0] rd_data_p1;
  logic                 vld_p1;

  assign in_rank  = host.command[RANK_BITS+CMD_BITS-1 -: RANK_BITS];
  assign in_read  = host.command[CMD_BITS-1];
  assign head     = rdq_mem[rd_ptr];

  assign transfer = held && rank_ready[hrank];
  assign rdq_full = (rdq_count == (PTR_BITS+1)'(RDQ_DEPTH));
  assign rdq_pop  = (rdq_count != '0) && rank_read_data_valid[head];
  // A read may enter a full queue only when the head retires in the same cycle.
  assign ready    = (!held || transfer) && (!in_read || !rdq_full || rdq_pop);
  assign accept   = host.valid && ready;
  assign push     = accept && in_read;
  assign pop_mask = rdq_pop ? (NUM_RANKS'(1) << head) : '0;

  assign host.ready           = ready;
  assign host.read_data       = rd_data_p1;
  assign host.read_data_valid = vld_p1;

  assign rank_valid = held ? (NUM_RANKS'(1) << hrank) : '0;
  assign ba_cmd_pm  = rank_ba_cmd_pm[lrank*4 +: 4];

  // Fan the held command out to its rank; every other slice stays zero.
  always_comb begin
    rank_command    = '0;
    rank_write_data = '0;
    if (held) begin
      rank_command[hrank*CMD_BITS +: CMD_BITS]     = hcmd;
      rank_write_data[hrank*DATA_BITS +: DATA_BITS] = hdata;
    end
  end

  // Dispatch occupancy and last-served rank.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      held  <= 1'b0;
      lrank <= '0;
    end else begin
      if (transfer) lrank <= hrank;
      if (accept)        held <= 1'b1;
      else if (transfer) held <= 1'b0;
    end
  end

  // Dispatch payload; it is only meaningful while held is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      hrank <= in_rank;
      hcmd  <= host.command[CMD_BITS-1:0];
      hdata <= host.write_data;
    end
  end

  // Read-order queue pointers and occupancy; simultaneous push and pop cancel.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rdq_count <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (rdq_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, rdq_pop})
        2'b10:   rdq_count <= rdq_count + 1'b1;
        2'b01:   rdq_count <= rdq_count - 1'b1;
        default: rdq_count <= rdq_count;
      endcase
    end
  end

  // Read-order queue storage.
  always_ff @(posedge clk) begin
    if (push) rdq_mem[wr_ptr] <= in_rank;
  end

  // Return stage p1: capture the head rank's data; stray strobes latch the error.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
      order_err  <= 1'b0;
    end else begin
      vld_p1 <= rdq_pop;
      if (rdq_pop) rd_data_p1 <= rank_read_data[head*DATA_BITS +: DATA_BITS];
      if (|(rank_read_data_valid & ~pop_mask)) order_err <= 1'b1;
    end
  end

endmodule

// File: doc/rank_dispatch.md
RANK_DISPATCH -- requirements
Module: rank_dispatch

Interface
REQ-001 Parameter NUM_RANKS, 4, number of rank slice controllers; power of 2, range 2..8.
REQ-002 Parameter RANK_BITS, log2(NUM_RANKS), width of the rank-select field.
REQ-003 Parameter CMD_BITS, 32, per-rank command width; bit CMD_BITS-1 is r_w (1 = read, 0 = write).
REQ-004 Parameter DATA_BITS, `DQ_BITS*8, width of the write and read data.
REQ-005 Parameter RDQ_DEPTH, 8, read-order queue depth; power of 2, range 2..32.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 power_on_rst_n  in  1  asynchronous, active-low reset.
REQ-008 command  in  RANK_BITS+CMD_BITS  upper RANK_BITS select the rank; the lower CMD_BITS are the rank command.
REQ-009 valid  in  1  command and write_data are valid.
REQ-010 ready  out  1  block accepts the command this cycle.
REQ-011 write_data  in  DATA_BITS  write payload.
REQ-012 rank_command  out  NUM_RANKS*CMD_BITS  per-rank command slices; rank r occupies [r*CMD_BITS +: CMD_BITS].
REQ-013 rank_write_data  out  NUM_RANKS*DATA_BITS  per-rank write data slices.
REQ-014 rank_valid  out  NUM_RANKS  per-rank command valid.
REQ-015 rank_ready  in  NUM_RANKS  per-rank command accept.
REQ-016 rank_read_data  in  NUM_RANKS*DATA_BITS  per-rank read data.
REQ-017 rank_read_data_valid  in  NUM_RANKS  per-rank read data strobe.
REQ-018 rank_ba_cmd_pm  in  NUM_RANKS*4  per-rank {power_up,power_down,refresh,write/read/active} status.
REQ-019 read_data  out  DATA_BITS  in-order read return.
REQ-020 read_data_valid  out  1  one-cycle strobe qualifying read_data.
REQ-021 ba_cmd_pm  out  4  status of the rank that last received a command.
REQ-022 rdq_count  out  log2(RDQ_DEPTH)+1  number of outstanding reads.
REQ-023 order_err  out  1  sticky out-of-order return flag.

Function
REQ-024 The block SHALL have a one-entry dispatch register {held, hrank, hcmd, hdata}; an accept (valid && ready) loads it on the next edge.
REQ-025 rank_valid[r] SHALL be held && hrank==r; the non-selected rank_command and rank_write_data slices SHALL be all zero.
REQ-026 A transfer SHALL occur when rank_valid[hrank] && rank_ready[hrank]; held then clears unless a new accept reloads it in the same cycle.
REQ-027 ready SHALL be (!held || transfer) && (command is a write || rdq_count<RDQ_DEPTH || rdq_pop).
REQ-028 Latency: an accept at cycle T SHALL present rank_valid at T+1; sustained throughput is one command per cycle while rank_ready=1.
REQ-029 An accepted read SHALL push its rank index into the read-order queue at acceptance.
REQ-030 rdq_pop SHALL be (rdq_count!=0) && rank_read_data_valid[head]; the selected rank_read_data is registered into read_data, and read_data_valid=1 at the next cycle.
REQ-031 A strobe from a rank other than head, or any strobe while the queue is empty, SHALL be dropped and SHALL set order_err, which clears only on reset.
REQ-032 A simultaneous push and pop SHALL leave rdq_count unchanged, including at full; pointers SHALL wrap modulo RDQ_DEPTH.
REQ-033 ba_cmd_pm SHALL equal rank_ba_cmd_pm slice lrank, where lrank is a register updated to hrank on each transfer.
REQ-034 read_data SHALL hold its last value when read_data_valid=0.

Reset
REQ-035 When power_on_rst_n=0, the block SHALL immediately clear held, rank_valid, read_data, read_data_valid, ba_cmd_pm source lrank (to 0), rdq_count, the queue pointers, and order_err.
REQ-036 A reset during operation SHALL discard the held command and all outstanding reads; late rank strobes after reset SHALL set order_err.

Verification
REQ-037 Reset, then a write to rank 2 with rank_ready=4'b1111 -> rank_valid=4'b0100 one cycle later, with the other slices zero.
REQ-038 Reads to ranks 1, 3, 0, then returns in the order 1, 3, 0 -> three read_data_valid pulses with the matching data; rdq_count returns to 0.
REQ-039 Rank 3 returns before the expected rank 1 -> the data is dropped, order_err=1, and rdq_count is unchanged.
REQ-040 Eight reads with no returns (RDQ_DEPTH=8) -> ready=0 for the ninth read while writes are still accepted; a return in that cycle lets the read be accepted with rdq_count staying at 8.
REQ-041 rank_ready[2]=0 with a held command to rank 2 -> ready=0 and the command is held stable until rank_ready[2]=1.
REQ-042 Reset asserted with 3 reads outstanding -> rdq_count=0 and read_data_valid=0 immediately.
